// File: rtl/jt49_eg_pkg.sv
// Shared constants and shape decode for the JT49 multi-channel envelope generator.
package jt49_eg_pkg;

  localparam int unsigned CTRL_CONT = 3;
  localparam int unsigned CTRL_ATT  = 2;
  localparam int unsigned CTRL_ALT  = 1;
  localparam int unsigned CTRL_HOLD = 0;

  function automatic logic will_hold(input logic [3:0] ctrl);
    return !ctrl[CTRL_CONT] || ctrl[CTRL_HOLD];
  endfunction

  function automatic logic will_invert(input logic [3:0] ctrl);
    return (!ctrl[CTRL_CONT] && ctrl[CTRL_ATT]) || (ctrl[CTRL_CONT] && ctrl[CTRL_ALT]);
  endfunction

endpackage

// File: rtl/jt49_eg_ch.sv
// One envelope channel: period divider, restart latch, gain/invert state, output register.
// Hold-entry pulse on done is generated only when JT49_EG_DONE_EN is defined.
module jt49_eg_ch
  import jt49_eg_pkg::*;
#(
  parameter int unsigned GW = 5,
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          restart,
  input  logic [3:0]    ctrl,
  input  logic [PW-1:0] period,
  output logic [GW-1:0] env,
  output logic          done
);

  logic [GW-1:0] gain_q, gain_d;
  logic [GW-1:0] env_q, env_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          inv_q, inv_d;
  logic          stop_q, stop_d;
  logic          rlatch_q, rlatch_d;
  logic          step;
  logic          hold_entry;

  // Restart is captured on any clk edge and only released by the cen edge that reloads.
  always_comb begin
    rlatch_d   = restart | (rlatch_q & ~cen);
    step       = (cnt_q >= (period - PW'(1))) || (period == '0);
    gain_d     = gain_q;
    inv_d      = inv_q;
    stop_d     = stop_q;
    cnt_d      = cnt_q;
    env_d      = env_q;
    hold_entry = 1'b0;
    if (cen) begin
      env_d = inv_q ? ~gain_q : gain_q;
      if (rlatch_q) begin
        gain_d = '1;
        inv_d  = ctrl[CTRL_ATT];
        stop_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = step ? '0 : cnt_q + PW'(1);
        if (step && !stop_q) begin
          if (gain_q != '0) begin
            gain_d = gain_q - GW'(1);
          end else begin
            if (will_hold(ctrl)) begin
              stop_d     = 1'b1;
              hold_entry = 1'b1;
            end else begin
              gain_d = '1;
            end
            if (will_invert(ctrl)) inv_d = ~inv_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain_q   <= '1;
      inv_q    <= 1'b0;
      stop_q   <= 1'b0;
      cnt_q    <= '0;
      rlatch_q <= 1'b0;
      env_q    <= '0;
    end else begin
      gain_q   <= gain_d;
      inv_q    <= inv_d;
      stop_q   <= stop_d;
      cnt_q    <= cnt_d;
      rlatch_q <= rlatch_d;
      env_q    <= env_d;
    end
  end

  assign env = env_q;

`ifdef JT49_EG_DONE_EN
  logic done_q, done_d;

  always_comb begin
    done_d = hold_entry & ~restart;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

endmodule

// File: rtl/jt49_eg_mc.sv
// Multi-channel AY/YM envelope generator: CH independent jt49_eg_ch engines on packed buses.
// Optional hold-entry pulse on done enabled by defining JT49_EG_DONE_EN.
module jt49_eg_mc
  import jt49_eg_pkg::*;
#(
  parameter int unsigned CH = 3,
  parameter int unsigned GW = 5,
  parameter int unsigned PW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [CH-1:0]   restart,
  input  logic [4*CH-1:0] ctrl,
  input  logic [PW*CH-1:0] period,
  output logic [GW*CH-1:0] env,
  output logic [CH-1:0]   done
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jt49_eg_ch #(
      .GW(GW),
      .PW(PW)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .cen    (cen),
      .restart(restart[g]),
      .ctrl   (ctrl[4*g +: 4]),
      .period (period[PW*g +: PW]),
      .env    (env[GW*g +: GW]),
      .done   (done[g])
    );
  end

endmodule

// File: tb/tb_jt49_eg_mc.sv
// Directed self-checking bench for jt49_eg_mc (CH=3, GW=5, PW=16).
module tb_jt49_eg_mc;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic [2:0]  restart;
  logic [11:0] ctrl;
  logic [47:0] period;
  logic [14:0] env;
  logic [2:0]  done;

  int unsigned chk_cnt;
  int unsigned pass_cnt;

  jt49_eg_mc #(
    .CH(3),
    .GW(5),
    .PW(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .restart(restart),
    .ctrl   (ctrl),
    .period (period),
    .env    (env),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef JT49_EG_DONE_EN
  localparam logic DONE_ON = 1'b1;
`else
  localparam logic DONE_ON = 1'b0;
`endif

  function automatic logic [4:0] env_of(input int unsigned ch);
    return env[ch*5 +: 5];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int unsigned ch, input logic [3:0] c, input logic [15:0] p);
    ctrl[ch*4 +: 4]    = c;
    period[ch*16 +: 16] = p;
  endtask

  // Restart pulse on edge E0, reload on E1 (cen held high).
  task automatic restart_and_reload(input logic [2:0] mask);
    restart = mask;
    tick();
    restart = '0;
    tick();
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (env !== 15'd0) $display("FAIL reset_env: got %h want %h", env, 15'd0);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 3'd0) $display("FAIL reset_done: got %b want %b", done, 3'd0);
    else pass_cnt++;
  endtask

  task automatic test_decay_hold();
    logic [4:0] exp_env;
    logic       exp_done;
    set_ch(0, 4'b0000, 16'd1);
    restart_and_reload(3'b001);
    for (int k = 0; k < 36; k++) begin
      tick();
      exp_env  = (k < 32) ? 5'(31 - k) : 5'd0;
      exp_done = DONE_ON && (k == 31);
      chk_cnt++;
      if (env_of(0) !== exp_env) $display("FAIL decay_env k=%0d: got %0d want %0d", k, env_of(0), exp_env);
      else pass_cnt++;
      chk_cnt++;
      if (done[0] !== exp_done) $display("FAIL decay_done k=%0d: got %b want %b", k, done[0], exp_done);
      else pass_cnt++;
    end
  endtask

  task automatic test_triangle();
    logic [4:0] exp_env;
    int         v;
    set_ch(0, 4'b1110, 16'd2);
    restart_and_reload(3'b001);
    for (int j = 0; j < 200; j++) begin
      tick();
      v = (j % 64) / 2;
      exp_env = ((j / 64) % 2 == 1) ? 5'(31 - v) : 5'(v);
      chk_cnt++;
      if (env_of(0) !== exp_env) $display("FAIL triangle_env j=%0d: got %0d want %0d", j, env_of(0), exp_env);
      else pass_cnt++;
      chk_cnt++;
      if (done[0] !== 1'b0) $display("FAIL triangle_done j=%0d: got %b want 0", j, done[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_decay_invert_hold();
    logic [4:0] exp_env;
    set_ch(0, 4'b1011, 16'd0);
    restart_and_reload(3'b001);
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_env = (k < 32) ? 5'(31 - k) : 5'd31;
      chk_cnt++;
      if (env_of(0) !== exp_env) $display("FAIL fall_hold31 k=%0d: got %0d want %0d", k, env_of(0), exp_env);
      else pass_cnt++;
    end
  endtask

  task automatic test_attack_hold();
    logic [4:0] exp_env;
    set_ch(0, 4'b1101, 16'd1);
    restart_and_reload(3'b001);
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_env = (k < 32) ? 5'(k) : 5'd31;
      chk_cnt++;
      if (env_of(0) !== exp_env) $display("FAIL rise_hold k=%0d: got %0d want %0d", k, env_of(0), exp_env);
      else pass_cnt++;
    end
  endtask

  task automatic test_cen_quarter();
    set_ch(0, 4'b0000, 16'd1);
    cen = 1'b0;
    tick();
    restart = 3'b001;
    tick();
    restart = '0;
    tick();
    tick();
    cen = 1'b1;
    tick();
    cen = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    cen = 1'b1;
    tick();
    cen = 1'b0;
    chk_cnt++;
    if (env_of(0) !== 5'd31) $display("FAIL cen_quarter_reload: got %0d want 31", env_of(0));
    else pass_cnt++;
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++;
    if (env_of(0) !== 5'd31) $display("FAIL cen_quarter_frozen: got %0d want 31", env_of(0));
    else pass_cnt++;
    cen = 1'b1;
    tick();
    chk_cnt++;
    if (env_of(0) !== 5'd30) $display("FAIL cen_quarter_step: got %0d want 30", env_of(0));
    else pass_cnt++;
  endtask

  task automatic test_restart_step();
    set_ch(0, 4'b0000, 16'd1);
    restart_and_reload(3'b001);
    for (int i = 0; i < 10; i++) tick();
    chk_cnt++;
    if (env_of(0) !== 5'd22) $display("FAIL midramp_env: got %0d want 22", env_of(0));
    else pass_cnt++;
    restart_and_reload(3'b001);
    tick();
    chk_cnt++;
    if (env_of(0) !== 5'd31) $display("FAIL restart_vs_step: got %0d want 31", env_of(0));
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (env_of(0) !== 5'd30) $display("FAIL restart_vs_step_next: got %0d want 30", env_of(0));
    else pass_cnt++;
  endtask

  task automatic test_periods();
    logic [4:0]  exp_env;
    int unsigned p;
    set_ch(0, 4'b0000, 16'd1);
    set_ch(1, 4'b0000, 16'd3);
    set_ch(2, 4'b0000, 16'd7);
    restart_and_reload(3'b111);
    for (int k = 0; k < 22; k++) begin
      tick();
      for (int unsigned ch = 0; ch < 3; ch++) begin
        p = (ch == 0) ? 1 : (ch == 1) ? 3 : 7;
        exp_env = 5'(31 - (k / p));
        chk_cnt++;
        if (env_of(ch) !== exp_env) $display("FAIL period_ch%0d k=%0d: got %0d want %0d", ch, k, env_of(ch), exp_env);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midramp();
    set_ch(0, 4'b0000, 16'd1);
    restart_and_reload(3'b001);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    chk_cnt++;
    if (env !== 15'd0) $display("FAIL midreset_env: got %h want 0", env);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 3'd0) $display("FAIL midreset_done: got %b want 0", done);
    else pass_cnt++;
    rst_n = 1'b1;
    restart_and_reload(3'b001);
    tick();
    chk_cnt++;
    if (env_of(0) !== 5'd31) $display("FAIL post_reset_ramp0: got %0d want 31", env_of(0));
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (env_of(0) !== 5'd30) $display("FAIL post_reset_ramp1: got %0d want 30", env_of(0));
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    cen      = 1'b1;
    restart  = '0;
    ctrl     = '0;
    period   = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    test_decay_hold();
    test_triangle();
    test_decay_invert_hold();
    test_attack_hold();
    test_cen_quarter();
    test_restart_step();
    test_periods();
    test_reset_midramp();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/jt49_eg_mc.md
# jt49_eg_mc

Multi-channel, width-parametrised envelope generator for the JT49 PSG core. Instantiates `CH` independent AY/YM envelope engines, each with its own shape control, restart strobe and built-in envelope-period divider, so the upstream block no longer generates step pulses. Sits between the register file and the per-channel volume/DAC mixer, clocked by the core's divided clock gated with `cen`.

## Interface
Parameters:
- `CH`, 3: number of channels.
- `GW`, 5: gain/envelope width in bits; full scale is all ones.
- `PW`, 16: envelope period width in bits.

Ports:
- `clk`, input, 1: core clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `cen`, input, 1: clock enable; all state advances only when high, except restart latching.
- `restart`, input, CH: per-channel restart strobe, sampled every `clk`.
- `ctrl`, input, 4*CH: shape per channel, {CONT, ATT, ALT, HOLD}; channel i in bits [4i+3:4i].
- `period`, input, PW*CH: envelope period per channel, in `cen` ticks.
- `env`, output, GW*CH: envelope level per channel; registered.
- `done`, output, CH: hold-entry pulse; see Configuration.

## Operation
Per channel i, with state `gain[GW]`, `inv`, `stop`, `cnt[PW]` and `rlatch`:
- `will_hold = !CONT || HOLD`; `will_invert = (!CONT && ATT) || (CONT && ALT)`.
- `rlatch` sets on any `clk` edge with `restart[i]=1`. It clears on the `cen` cycle that applies the reload.
- Reload on a `cen` cycle with `rlatch=1`:
  - `gain` set to all ones; `inv` set to ATT; `stop` set to 0; `cnt` set to 0.
  - No step is taken that cycle; reload wins over a simultaneous step.
- Divider:
  - Each `cen` cycle, `step = (cnt >= period-1) || period==0`.
  - On step, `cnt` goes to 0; otherwise `cnt` goes to `cnt+1`.
  - Period 0 and 1 both step every `cen`.
  - A period lowered below `cnt` steps at once.
- On step with `stop=0`:
  - `gain != 0`: `gain` becomes `gain-1`.
  - `gain == 0` and `will_hold`: `stop` becomes 1.
  - `gain == 0` and not `will_hold`: `gain` wraps to all ones.
  - `gain == 0`: `inv` toggles if `will_invert`.
- With `stop=1`, `cnt` still runs, but `gain` and `inv` are frozen until restart.
- Output: `env` is `inv ? ~gain : gain`, registered on `cen`.
- `ctrl` is read live. A change without restart takes effect at the next hold/invert decision.
- Channels share nothing but `clk`, `cen` and `rst_n`.

## Timing
- Reset (`rst_n=0` at `clk` edge, regardless of `cen`):
  - `gain` all ones; `inv`, `stop`, `cnt` and `rlatch` cleared; `env=0`; `done=0`.
  - Reset mid-ramp discards all progress.
- `restart` may be a single `clk` pulse between `cen` cycles and is never lost.
- Restart latency:
  - Reload happens at the first `cen` edge after the latch.
  - `env` shows the reloaded value (all ones if ATT=0, 0 if ATT=1) at the next `cen` edge.
- `env` lags the `gain`/`inv` update by exactly one `cen` cycle.
- With period P, one full ramp takes `2^GW * P` `cen` cycles.

## Configuration
- `JT49_EG_DONE_EN` defined:
  - `done[i]` pulses high for one `cen`-qualified `clk` cycle on the cycle `stop` goes 0→1.
  - Reset and restart clear `done`.
- `JT49_EG_DONE_EN` undefined: `done` is tied to 0 and no logic is generated; the port list is unchanged.

## Structure
- Package `jt49_eg_pkg` contains:
  - ctrl bit index constants `CTRL_CONT=3`, `CTRL_ATT=2`, `CTRL_ALT=1`, `CTRL_HOLD=0`;
  - functions `will_hold(ctrl)` and `will_invert(ctrl)`.
- Sub-module `jt49_eg_ch` is one channel: divider, restart latch, gain state, output register.
- The top instantiates `jt49_eg_ch` `CH` times with a generate loop, slicing the packed buses.

## Test plan
- Use `CH=3`, `GW=5`, `PW=16`, `cen` every clock unless noted.
- Reset, then restart ch0 with ctrl=0000 and period=1 -> `env0` goes 31,30,…,0, then holds 0; `done0` pulses once.
- ctrl=1110 (triangle), period=2 -> `env` rises 0→31, then falls 31→0, each level held 2 `cen`; repeats indefinitely; never stops.
- ctrl=1011, period=0 -> falls 31→0, then holds at 31.
- ctrl=1101 -> rises 0→31, then holds at 31.
- `cen` at 1/4 rate with a 1-clk `restart` pulse between `cen` edges -> reload applied at the next `cen`; `env`=31 one `cen` later.
- `restart` and a step coincide on the same `cen` -> `gain`=31, not 30.
- Different periods on ch0/1/2 (1, 3, 7) -> ch1 and ch2 step at 1/3 and 1/7 of the ch0 rate.
- Reset mid-ramp -> all `env`=0, and the ramp restarts from 31 on the next restart.
